// File: rtl/atm_keypad_entry.sv
// Keypad front-end for the ATM core: builds the binary account number and PIN from
// decimal key presses, runs the authentication handshake, and enforces lockout/timeout.
module atm_keypad_entry #(
  parameter int MAX_TRIES    = 3,
  parameter int LOCK_CYCLES  = 1000,
  parameter int IDLE_TIMEOUT = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        auth_done,
  input  logic        auth_ok,
  input  logic        logout,
  output logic [11:0] acc_number,
  output logic [3:0]  pin,
  output logic        req,
  output logic        logged_in,
  output logic        locked,
  output logic        error,
  output logic        exit
);

  localparam int LW = $clog2(LOCK_CYCLES + 1);
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [LW-1:0] LOCK_LOAD   = LW'(LOCK_CYCLES);
  localparam logic [LW-1:0] LOCK_ONE    = LW'(1);
  localparam logic [IW-1:0] IDLE_LAST   = IW'(IDLE_TIMEOUT - 1);
  localparam logic [IW-1:0] IDLE_ONE    = IW'(1);
  localparam logic [1:0]    TRIES_LIMIT = 2'(MAX_TRIES);

  typedef enum logic [2:0] {
    S_ACC,
    S_PIN,
    S_REQ,
    S_SESSION,
    S_LOCKED
  } state_t;

  state_t          state;
  logic [13:0]     acc_acc;
  logic [2:0]      digit_cnt;
  logic            pin_valid;
  logic [1:0]      tries;
  logic [LW-1:0]   lock_cnt;
  logic [IW-1:0]   idle_cnt;

  logic        is_digit;
  logic        is_clear;
  logic        is_enter;
  logic        is_cancel;
  logic        idle_run;
  logic        idle_fire;
  logic [13:0] acc_next;
  logic [1:0]  tries_next;

  assign is_digit   = key_valid && (key_code <= 4'd9);
  assign is_clear   = key_valid && (key_code == 4'hA);
  assign is_enter   = key_valid && (key_code == 4'hB);
  assign is_cancel  = key_valid && (key_code == 4'hC);
  // The timer only runs while a partial entry exists; a key on the same edge wins.
  assign idle_run   = ((state == S_ACC) && (digit_cnt != 3'd0)) || (state == S_PIN);
  assign idle_fire  = idle_run && !key_valid && (idle_cnt == IDLE_LAST);
  assign acc_next   = acc_acc * 14'd10 + {10'd0, key_code};
  assign tries_next = tries + 2'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_ACC;
      acc_acc    <= '0;
      digit_cnt  <= '0;
      pin_valid  <= 1'b0;
      tries      <= '0;
      lock_cnt   <= '0;
      idle_cnt   <= '0;
      acc_number <= '0;
      pin        <= '0;
      req        <= 1'b0;
      logged_in  <= 1'b0;
      locked     <= 1'b0;
      error      <= 1'b0;
      exit       <= 1'b0;
    end else begin
      error <= 1'b0;
      exit  <= 1'b0;
      case (state)
        S_ACC, S_PIN: begin
          if (is_cancel || idle_fire) begin
            acc_acc    <= '0;
            digit_cnt  <= '0;
            acc_number <= '0;
            pin        <= '0;
            pin_valid  <= 1'b0;
            idle_cnt   <= '0;
            error      <= idle_fire;
            state      <= S_ACC;
          end else if (key_valid) begin
            idle_cnt <= '0;
            if (state == S_ACC) begin
              if (is_digit && (digit_cnt != 3'd4)) begin
                acc_acc   <= acc_next;
                digit_cnt <= digit_cnt + 3'd1;
              end else if (is_clear) begin
                acc_acc   <= '0;
                digit_cnt <= '0;
              end else if (is_enter) begin
                if ((digit_cnt == 3'd4) && (acc_acc <= 14'd4095)) begin
                  acc_number <= acc_acc[11:0];
                  state      <= S_PIN;
                end else begin
                  error     <= 1'b1;
                  acc_acc   <= '0;
                  digit_cnt <= '0;
                end
              end
            end else begin
              if (is_digit && !pin_valid) begin
                pin       <= key_code;
                pin_valid <= 1'b1;
              end else if (is_clear) begin
                pin       <= '0;
                pin_valid <= 1'b0;
              end else if (is_enter) begin
                if (pin_valid) begin
                  req   <= 1'b1;
                  state <= S_REQ;
                end else begin
                  error <= 1'b1;
                end
              end
            end
          end else if (idle_run) begin
            idle_cnt <= idle_cnt + IDLE_ONE;
          end else begin
            idle_cnt <= '0;
          end
        end

        S_REQ: begin
          if (auth_done) begin
            req <= 1'b0;
            if (auth_ok) begin
              logged_in <= 1'b1;
              tries     <= '0;
              state     <= S_SESSION;
            end else begin
              tries      <= tries_next;
              acc_acc    <= '0;
              digit_cnt  <= '0;
              acc_number <= '0;
              pin        <= '0;
              pin_valid  <= 1'b0;
              if (tries_next == TRIES_LIMIT) begin
                locked   <= 1'b1;
                lock_cnt <= LOCK_LOAD;
                state    <= S_LOCKED;
              end else begin
                error <= 1'b1;
                state <= S_ACC;
              end
            end
          end
        end

        S_SESSION: begin
          // CANCEL and logout together still end the session with a single pulse.
          if (is_cancel || logout) begin
            exit       <= 1'b1;
            logged_in  <= 1'b0;
            acc_acc    <= '0;
            digit_cnt  <= '0;
            acc_number <= '0;
            pin        <= '0;
            pin_valid  <= 1'b0;
            state      <= S_ACC;
          end
        end

        S_LOCKED: begin
          if (lock_cnt <= LOCK_ONE) begin
            lock_cnt <= '0;
            locked   <= 1'b0;
            tries    <= '0;
            state    <= S_ACC;
          end else begin
            lock_cnt <= lock_cnt - LOCK_ONE;
          end
        end

        default: state <= S_ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_atm_keypad_entry.sv
// Bench for atm_keypad_entry: directed scenarios plus randomized sessions checked
// against a digit-queue reference model of the keypad rules.
module tb_atm_keypad_entry;

  localparam int MAX_TRIES    = 3;
  localparam int LOCK_CYCLES  = 1000;
  localparam int IDLE_TIMEOUT = 500;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'd0;
  logic        auth_done = 1'b0;
  logic        auth_ok = 1'b0;
  logic        logout = 1'b0;
  logic [11:0] acc_number;
  logic [3:0]  pin;
  logic        req;
  logic        logged_in;
  logic        locked;
  logic        error;
  logic        exit;

  int checks = 0;
  int failures = 0;

  atm_keypad_entry #(
    .MAX_TRIES   (MAX_TRIES),
    .LOCK_CYCLES (LOCK_CYCLES),
    .IDLE_TIMEOUT(IDLE_TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_code  (key_code),
    .auth_done (auth_done),
    .auth_ok   (auth_ok),
    .logout    (logout),
    .acc_number(acc_number),
    .pin       (pin),
    .req       (req),
    .logged_in (logged_in),
    .locked    (locked),
    .error     (error),
    .exit      (exit)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  typedef enum {M_ACC, M_PIN, M_REQ, M_SES, M_LOCK} mode_t;

  mode_t m_mode;
  int    m_digits[$];
  int    m_acc;
  int    m_pin;
  bit    m_pin_has;
  int    m_tries;
  int    m_lock_left;
  int    m_idle;
  bit    m_err;
  bit    m_exit;

  function automatic void model_clear();
    m_digits.delete();
    m_acc     = 0;
    m_pin     = 0;
    m_pin_has = 0;
    m_idle    = 0;
  endfunction

  function automatic void model_reset();
    model_clear();
    m_mode      = M_ACC;
    m_tries     = 0;
    m_lock_left = 0;
    m_err       = 0;
    m_exit      = 0;
  endfunction

  function automatic void model_step(bit kv, logic [3:0] kc, bit ad, bit ao, bit lo);
    int v;
    bit running;
    m_err  = 0;
    m_exit = 0;
    case (m_mode)
      M_ACC, M_PIN: begin
        running = (m_mode == M_PIN) || (m_digits.size() > 0);
        if (kv) begin
          m_idle = 0;
          if (kc == 4'hC) begin
            model_clear();
            m_mode = M_ACC;
          end else if (m_mode == M_ACC) begin
            if (kc <= 4'd9) begin
              if (m_digits.size() < 4) m_digits.push_back(int'(kc));
            end else if (kc == 4'hA) begin
              m_digits.delete();
            end else if (kc == 4'hB) begin
              v = 0;
              foreach (m_digits[i]) v = v * 10 + m_digits[i];
              if (m_digits.size() == 4 && v <= 4095) begin
                m_acc  = v;
                m_mode = M_PIN;
              end else begin
                m_err = 1;
                m_digits.delete();
              end
            end
          end else begin
            if (kc <= 4'd9) begin
              if (!m_pin_has) begin
                m_pin     = int'(kc);
                m_pin_has = 1;
              end
            end else if (kc == 4'hA) begin
              m_pin     = 0;
              m_pin_has = 0;
            end else if (kc == 4'hB) begin
              if (m_pin_has) m_mode = M_REQ;
              else m_err = 1;
            end
          end
        end else if (running) begin
          m_idle++;
          if (m_idle == IDLE_TIMEOUT) begin
            model_clear();
            m_err  = 1;
            m_mode = M_ACC;
          end
        end else begin
          m_idle = 0;
        end
      end
      M_REQ: begin
        if (ad) begin
          if (ao) begin
            m_mode  = M_SES;
            m_tries = 0;
          end else begin
            m_tries++;
            model_clear();
            if (m_tries == MAX_TRIES) begin
              m_mode      = M_LOCK;
              m_lock_left = LOCK_CYCLES;
            end else begin
              m_err  = 1;
              m_mode = M_ACC;
            end
          end
        end
      end
      M_SES: begin
        if ((kv && kc == 4'hC) || lo) begin
          m_exit = 1;
          model_clear();
          m_mode = M_ACC;
        end
      end
      M_LOCK: begin
        m_lock_left--;
        if (m_lock_left == 0) begin
          m_mode  = M_ACC;
          m_tries = 0;
        end
      end
      default: m_mode = M_ACC;
    endcase
  endfunction

  function automatic logic [20:0] model_vec();
    return {12'(m_acc), 4'(m_pin), m_mode == M_REQ, m_mode == M_SES, m_mode == M_LOCK,
            m_err, m_exit};
  endfunction

  function automatic logic [20:0] dut_vec();
    return {acc_number, pin, req, logged_in, locked, error, exit};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input bit kv, input logic [3:0] kc, input bit ad, input bit ao,
                      input bit lo);
    key_valid = kv;
    key_code  = kc;
    auth_done = ad;
    auth_ok   = ao;
    logout    = lo;
    @(posedge clk);
    if (rst_n) model_step(kv, kc, ad, ao, lo);
    else model_reset();
    #1;
    key_valid = 1'b0;
    auth_done = 1'b0;
    logout    = 1'b0;
  endtask

  task automatic press(input logic [3:0] k);
    step(1'b1, k, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle_cycle();
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic enter_creds(input int acc, input int pin_d);
    press(4'(acc / 1000));
    press(4'((acc / 100) % 10));
    press(4'((acc / 10) % 10));
    press(4'(acc % 10));
    press(4'hB);
    press(4'(pin_d));
    press(4'hB);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dut_vec() !== 21'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %h expected 0", dut_vec());
    end
    rst_n = 1'b1;
    model_reset();
    idle_cycle();
    checks++;
    if (dut_vec() !== model_vec()) begin
      failures++;
      $display("FAIL reset_release: got %h expected %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_login();
    int seq[7] = '{2, 7, 4, 9, 11, 0, 11};
    foreach (seq[i]) press(4'(seq[i]));
    checks++;
    if ({req, acc_number, pin} !== {1'b1, 12'd2749, 4'd0}) begin
      failures++;
      $display("FAIL login_req: req=%0b acc=%0d pin=%0d expected req=1 acc=2749 pin=0",
               req, acc_number, pin);
    end
    repeat (3) press(4'($urandom_range(0, 15)));
    checks++;
    if ({req, acc_number, pin, logged_in} !== {1'b1, 12'd2749, 4'd0, 1'b0}) begin
      failures++;
      $display("FAIL login_hold: req=%0b acc=%0d pin=%0d li=%0b expected 1/2749/0/0",
               req, acc_number, pin, logged_in);
    end
    step(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    checks++;
    if ({logged_in, req, error} !== 3'b100) begin
      failures++;
      $display("FAIL login_result: li=%0b req=%0b err=%0b expected li=1 req=0 err=0",
               logged_in, req, error);
    end
    press(4'd5);
    press(4'hB);
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (dut_vec() !== model_vec() || logged_in !== 1'b1) begin
      failures++;
      $display("FAIL session_ignores: got %h expected %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_session_end();
    int pulses;
    press(4'hC);
    checks++;
    if ({exit, logged_in, acc_number} !== {1'b1, 1'b0, 12'd0}) begin
      failures++;
      $display("FAIL cancel_exit: exit=%0b li=%0b acc=%0d expected 1/0/0",
               exit, logged_in, acc_number);
    end
    idle_cycle();
    checks++;
    if (exit !== 1'b0) begin
      failures++;
      $display("FAIL exit_width: exit=%0b expected 0", exit);
    end
    enter_creds(2749, 5);
    step(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    pulses = 0;
    step(1'b1, 4'hC, 1'b0, 1'b0, 1'b1);
    pulses += int'(exit);
    repeat (3) begin
      idle_cycle();
      pulses += int'(exit);
    end
    checks++;
    if (pulses != 1 || logged_in !== 1'b0) begin
      failures++;
      $display("FAIL both_exit: pulses=%0d li=%0b expected pulses=1 li=0", pulses, logged_in);
    end
  endtask

  task automatic test_range_errors();
    int s1[5] = '{9, 9, 9, 9, 11};
    int s2[4] = '{2, 1, 7, 11};
    int s3[6] = '{2, 1, 7, 5, 3, 11};
    int s4[5] = '{4, 0, 9, 6, 11};
    foreach (s1[i]) press(4'(s1[i]));
    checks++;
    if ({error, acc_number} !== {1'b1, 12'd0}) begin
      failures++;
      $display("FAIL range_9999: err=%0b acc=%0d expected err=1 acc=0", error, acc_number);
    end
    idle_cycle();
    checks++;
    if (error !== 1'b0) begin
      failures++;
      $display("FAIL error_width: err=%0b expected 0", error);
    end
    foreach (s2[i]) press(4'(s2[i]));
    checks++;
    if (error !== 1'b1) begin
      failures++;
      $display("FAIL short_entry: err=%0b expected 1", error);
    end
    foreach (s4[i]) press(4'(s4[i]));
    checks++;
    if ({error, acc_number} !== {1'b1, 12'd0}) begin
      failures++;
      $display("FAIL range_4096: err=%0b acc=%0d expected err=1 acc=0", error, acc_number);
    end
    foreach (s3[i]) press(4'(s3[i]));
    checks++;
    if ({error, acc_number} !== {1'b0, 12'd2175}) begin
      failures++;
      $display("FAIL fifth_digit: err=%0b acc=%0d expected err=0 acc=2175", error, acc_number);
    end
    press(4'hB);
    checks++;
    if (error !== 1'b1) begin
      failures++;
      $display("FAIL pin_missing: err=%0b expected 1", error);
    end
    press(4'd8);
    press(4'hC);
    checks++;
    if ({error, acc_number, pin, req} !== 18'd0) begin
      failures++;
      $display("FAIL cancel_clear: err=%0b acc=%0d pin=%0d req=%0b expected all 0",
               error, acc_number, pin, req);
    end
  endtask

  task automatic test_lockout();
    int n;
    for (int t = 0; t < 2; t++) begin
      enter_creds(1234, 5);
      step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
      checks++;
      if ({error, locked, req} !== 3'b100) begin
        failures++;
        $display("FAIL fail_try%0d: err/lock/req=%b expected 100", t + 1, {error, locked, req});
      end
    end
    enter_creds(1234, 5);
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({error, locked, req} !== 3'b010) begin
      failures++;
      $display("FAIL lock_entry: err/lock/req=%b expected 010", {error, locked, req});
    end
    n = 0;
    do begin
      n++;
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end while (locked && n < LOCK_CYCLES + 100);
    checks++;
    if (n != LOCK_CYCLES) begin
      failures++;
      $display("FAIL lock_length: locked for %0d cycles expected %0d", n, LOCK_CYCLES);
    end
    checks++;
    if (dut_vec() !== model_vec()) begin
      failures++;
      $display("FAIL lock_release: got %h expected %h", dut_vec(), model_vec());
    end
    enter_creds(4095, 9);
    checks++;
    if ({req, acc_number, pin} !== {1'b1, 12'd4095, 4'd9}) begin
      failures++;
      $display("FAIL relogin_req: req=%0b acc=%0d pin=%0d expected 1/4095/9",
               req, acc_number, pin);
    end
    step(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({exit, logged_in} !== 2'b10) begin
      failures++;
      $display("FAIL relogin_logout: exit=%0b li=%0b expected exit=1 li=0", exit, logged_in);
    end
  endtask

  task automatic test_idle_timeout();
    bit seen;
    press(4'd2);
    press(4'd1);
    seen = 0;
    repeat (IDLE_TIMEOUT - 2) begin
      idle_cycle();
      seen |= error;
    end
    press(4'd3);
    seen |= error;
    repeat (IDLE_TIMEOUT - 1) begin
      idle_cycle();
      seen |= error;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL idle_early: error seen before timeout, expected none");
    end
    idle_cycle();
    checks++;
    if (error !== 1'b1 || dut_vec() !== model_vec()) begin
      failures++;
      $display("FAIL idle_fire: got %h expected %h", dut_vec(), model_vec());
    end
    press(4'hB);
    checks++;
    if (error !== 1'b1) begin
      failures++;
      $display("FAIL idle_cleared: err=%0b expected 1 (field should be empty)", error);
    end
    seen = 0;
    repeat (IDLE_TIMEOUT + 10) begin
      idle_cycle();
      seen |= error;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL idle_empty: error with empty field, expected none");
    end
  endtask

  task automatic test_reset_mid_req();
    bit seen_exit;
    for (int t = 0; t < 2; t++) begin
      enter_creds(3210, 4);
      step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    end
    enter_creds(3210, 4);
    checks++;
    if (req !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_req: req=%0b expected 1", req);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dut_vec() !== 21'd0) begin
      failures++;
      $display("FAIL async_reset: got %h expected 0", dut_vec());
    end
    seen_exit = 0;
    repeat (3) begin
      step(1'b0, 4'd0, 1'b1, 1'b1, 1'b1);
      seen_exit |= exit;
    end
    rst_n = 1'b1;
    model_reset();
    idle_cycle();
    seen_exit |= exit;
    checks++;
    if (seen_exit) begin
      failures++;
      $display("FAIL reset_exit: exit pulse seen around reset, expected none");
    end
    enter_creds(3210, 4);
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({error, locked} !== 2'b10) begin
      failures++;
      $display("FAIL tries_cleared: err=%0b locked=%0b expected err=1 locked=0", error, locked);
    end
  endtask

  typedef struct packed {
    logic       kv;
    logic [3:0] kc;
    logic       ad;
    logic       ao;
    logic       lo;
  } stim_t;

  stim_t sq[$];

  function automatic void push(bit kv, logic [3:0] kc, bit ad, bit ao, bit lo);
    sq.push_back({kv, kc, ad, ao, lo});
  endfunction

  function automatic void push_noise();
    push(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'b0, 1'b0, 1'b0);
  endfunction

  task automatic test_random();
    stim_t s;
    int guard;
    int nd;
    int r;
    guard = 0;
    for (int a = 0; a < 60; a++) begin
      sq.delete();
      nd = $urandom_range(3, 5);
      for (int i = 0; i < nd; i++) begin
        if ($urandom_range(0, 9) == 0) push(1'b1, 4'hA, 1'b0, 1'b0, 1'b0);
        push(1'b1, 4'((i == 0) ? $urandom_range(0, 5) : $urandom_range(0, 9)), 1'b0, 1'b0, 1'b0);
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) push(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      end
      if ($urandom_range(0, 14) == 0) repeat (IDLE_TIMEOUT + 5) push(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      push(1'b1, 4'hB, 1'b0, 1'b0, 1'b0);
      repeat ($urandom_range(0, 2)) push(1'b1, 4'($urandom_range(0, 9)), 1'b0, 1'b0, 1'b0);
      if ($urandom_range(0, 4) == 0) push(1'b1, 4'hA, 1'b0, 1'b0, 1'b0);
      if ($urandom_range(0, 19) == 0) push(1'b1, 4'hC, 1'b0, 1'b0, 1'b0);
      push(1'b1, 4'hB, 1'b0, 1'b0, 1'b0);
      repeat ($urandom_range(0, 3)) push_noise();
      push(1'b0, 4'd0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
      repeat ($urandom_range(0, 3)) push_noise();
      r = $urandom_range(0, 2);
      push(r != 0, 4'hC, 1'b0, 1'b0, r != 1);
      while ((sq.size() > 0 || m_mode == M_LOCK) && guard < 60000) begin
        if (sq.size() > 0) s = sq.pop_front();
        else s = '0;
        step(s.kv, s.kc, s.ad, s.ao, s.lo);
        guard++;
        checks++;
        if (dut_vec() !== model_vec()) begin
          failures++;
          $display("FAIL random_cycle%0d: got %h expected %h", guard, dut_vec(), model_vec());
        end
      end
    end
    checks++;
    if (guard >= 60000) begin
      failures++;
      $display("FAIL random_budget: cycle budget %0d exhausted", guard);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_login();
    test_session_end();
    test_range_errors();
    test_lockout();
    test_idle_timeout();
    test_reset_mid_req();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
